// File: rtl/collision_pkg.sv
// ---------------------------------------------------------------------------
// collision_pkg
//   Shared definitions for the car collision scanner and any render/move logic
//   that reasons about car footprints: board and car dimensions, orientation
//   codes, the car-entry record, scanner FSM states and footprint helpers.
//
//   Orientation code: bit0 = vertical, bit1 = long car.
// ---------------------------------------------------------------------------
package collision_pkg;

  localparam int NUM_CARS_DEF = 16;
  localparam int COORD_W      = 10;
  localparam int ORIENT_W     = 2;

  localparam int CAR_THICK = 40;
  localparam int CAR_SHORT = 80;
  localparam int CAR_LONG  = 120;
  localparam int FIELD_W   = 640;
  localparam int FIELD_H   = 480;

  localparam logic [ORIENT_W-1:0] ORIENT_H_SHORT = 2'd0;
  localparam logic [ORIENT_W-1:0] ORIENT_V_SHORT = 2'd1;
  localparam logic [ORIENT_W-1:0] ORIENT_H_LONG  = 2'd2;
  localparam logic [ORIENT_W-1:0] ORIENT_V_LONG  = 2'd3;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so x+w never wraps.
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef struct packed {
    coord_t                x;
    coord_t                y;
    logic [ORIENT_W-1:0]   orient;
  } car_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic coord_ext_t car_w(input logic [ORIENT_W-1:0] orient);
    if (orient[0]) car_w = coord_ext_t'(CAR_THICK);
    else           car_w = orient[1] ? coord_ext_t'(CAR_LONG) : coord_ext_t'(CAR_SHORT);
  endfunction

  function automatic coord_ext_t car_h(input logic [ORIENT_W-1:0] orient);
    if (!orient[0]) car_h = coord_ext_t'(CAR_THICK);
    else            car_h = orient[1] ? coord_ext_t'(CAR_LONG) : coord_ext_t'(CAR_SHORT);
  endfunction

endpackage

// File: rtl/car_overlap.sv
// ---------------------------------------------------------------------------
// car_overlap
//   Combinational footprint intersection of two cars. Footprints are half-open
//   rectangles [x, x+w) x [y, y+h), so cars that only touch edges do not
//   overlap. Shared by the scanner and by render/move logic.
// Ports:
//   a_x_i, a_y_i, a_orient_i   first car top-left and orientation
//   b_x_i, b_y_i, b_orient_i   second car top-left and orientation
//   overlap_o                  1 when the footprints intersect
// ---------------------------------------------------------------------------
module car_overlap
  import collision_pkg::*;
(
  input  logic [COORD_W-1:0]  a_x_i,
  input  logic [COORD_W-1:0]  a_y_i,
  input  logic [ORIENT_W-1:0] a_orient_i,
  input  logic [COORD_W-1:0]  b_x_i,
  input  logic [COORD_W-1:0]  b_y_i,
  input  logic [ORIENT_W-1:0] b_orient_i,
  output logic                overlap_o
);

  coord_ext_t a_l, a_t, a_r, a_b;
  coord_ext_t b_l, b_t, b_r, b_b;

  always_comb begin
    a_l = {1'b0, a_x_i};
    a_t = {1'b0, a_y_i};
    b_l = {1'b0, b_x_i};
    b_t = {1'b0, b_y_i};
    a_r = a_l + car_w(a_orient_i);
    a_b = a_t + car_h(a_orient_i);
    b_r = b_l + car_w(b_orient_i);
    b_b = b_t + car_h(b_orient_i);
    overlap_o = (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);
  end

endmodule

// File: rtl/collision_scanner.sv
// ---------------------------------------------------------------------------
// collision_scanner
//   Holds a table of NUM_CARS car entries and answers move queries by scanning
//   one entry per clock, reporting collision, lowest colliding index and
//   out-of-bounds. FSM: IDLE -> SCAN -> DONE -> IDLE.
//
//   Build option COLLISION_EARLY_EXIT_EN: when defined, the scan stops at the
//   first hit (result at accept+hit+2); misses still scan the full table.
//   Undefined: every query takes NUM_CARS+1 cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_idx, wr_x, wr_y, wr_orient, wr_valid
//                            table write; committed only while query_ready=1
//   query_valid / query_ready  query handshake (ready only in IDLE)
//   carX, carY, carOrient, carIndex  query car; its own index is skipped
//   result_valid             one-cycle pulse; result fields valid and held
//   collision                overlap with any valid entry, or out of bounds
//   hit_index                lowest overlapping index, 0 if none
//   out_of_bounds            query footprint exceeds the board
// ---------------------------------------------------------------------------
module collision_scanner
  import collision_pkg::*;
#(
  parameter  int NUM_CARS = NUM_CARS_DEF,
  localparam int IDX_W    = $clog2(NUM_CARS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [COORD_W-1:0]  wr_x,
  input  logic [COORD_W-1:0]  wr_y,
  input  logic [ORIENT_W-1:0] wr_orient,
  input  logic                wr_valid,
  input  logic                query_valid,
  output logic                query_ready,
  input  logic [COORD_W-1:0]  carX,
  input  logic [COORD_W-1:0]  carY,
  input  logic [ORIENT_W-1:0] carOrient,
  input  logic [IDX_W-1:0]    carIndex,
  output logic                result_valid,
  output logic                collision,
  output logic [IDX_W-1:0]    hit_index,
  output logic                out_of_bounds
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

  car_entry_t          table_q [NUM_CARS];
  logic [NUM_CARS-1:0] valid_q;

  scan_state_e         state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  car_entry_t          query_q, query_d;
  logic [IDX_W-1:0]    qidx_q, qidx_d;
  logic                oob_q, oob_d;
  logic                hit_found_q, hit_found_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                collision_q, collision_d;
  logic [IDX_W-1:0]    hit_index_q, hit_index_d;
  logic                out_of_bounds_q, out_of_bounds_d;

  logic                wr_commit;
  logic                entry_overlap;
  logic                entry_hit;
  logic                first_hit;
  logic                scan_end;

  car_overlap u_overlap (
    .a_x_i      (query_q.x),
    .a_y_i      (query_q.y),
    .a_orient_i (query_q.orient),
    .b_x_i      (table_q[ptr_q].x),
    .b_y_i      (table_q[ptr_q].y),
    .b_orient_i (table_q[ptr_q].orient),
    .overlap_o  (entry_overlap)
  );

  assign wr_commit = wr_en && query_ready;
  assign entry_hit = valid_q[ptr_q] && (ptr_q != qidx_q) && entry_overlap;
  assign first_hit = entry_hit && !hit_found_q;

`ifdef COLLISION_EARLY_EXIT_EN
  assign scan_end = (ptr_q == LAST_IDX) || first_hit;
`else
  assign scan_end = (ptr_q == LAST_IDX);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    query_d         = query_q;
    qidx_d          = qidx_q;
    oob_d           = oob_q;
    hit_found_d     = hit_found_q;
    hit_idx_d       = hit_idx_q;
    collision_d     = collision_q;
    hit_index_d     = hit_index_q;
    out_of_bounds_d = out_of_bounds_q;
    query_ready     = 1'b0;
    result_valid    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        query_ready = 1'b1;
        if (query_valid) begin
          query_d     = '{x: carX, y: carY, orient: carOrient};
          qidx_d      = carIndex;
          oob_d       = (({1'b0, carX} + car_w(carOrient)) > coord_ext_t'(FIELD_W)) ||
                        (({1'b0, carY} + car_h(carOrient)) > coord_ext_t'(FIELD_H));
          ptr_d       = '0;
          hit_found_d = 1'b0;
          hit_idx_d   = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Ascending scan: the first hit recorded is the lowest index.
        if (first_hit) begin
          hit_found_d = 1'b1;
          hit_idx_d   = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
        if (scan_end) begin
          collision_d     = hit_found_d || oob_q;
          hit_index_d     = hit_idx_d;
          out_of_bounds_d = oob_q;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      query_q         <= '0;
      qidx_q          <= '0;
      oob_q           <= 1'b0;
      hit_found_q     <= 1'b0;
      hit_idx_q       <= '0;
      collision_q     <= 1'b0;
      hit_index_q     <= '0;
      out_of_bounds_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      query_q         <= query_d;
      qidx_q          <= qidx_d;
      oob_q           <= oob_d;
      hit_found_q     <= hit_found_d;
      hit_idx_q       <= hit_idx_d;
      collision_q     <= collision_d;
      hit_index_q     <= hit_index_d;
      out_of_bounds_q <= out_of_bounds_d;
      if (wr_commit) valid_q[wr_idx] <= wr_valid;
    end
  end

  // NOTE: entry payload is deliberately not reset; clearing valid_q is enough
  // to empty the table and keeps the storage a plain register file.
  always_ff @(posedge clk) begin
    if (wr_commit) table_q[wr_idx] <= '{x: wr_x, y: wr_y, orient: wr_orient};
  end

  assign collision     = collision_q;
  assign hit_index     = hit_index_q;
  assign out_of_bounds = out_of_bounds_q;

endmodule

// File: tb/tb_collision_scanner.sv
// ---------------------------------------------------------------------------
// tb_collision_scanner
//   Scoreboard bench: the driver issues writes/queries and pushes the expected
//   result (from a rectangle-arithmetic model of the board) into a queue; a
//   monitor pops and compares whenever result_valid is seen.
// ---------------------------------------------------------------------------
module tb_collision_scanner;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [9:0] wr_x = '0, wr_y = '0;
  logic [1:0] wr_orient = '0;
  logic       wr_valid = 1'b0;
  logic       query_valid = 1'b0;
  logic       query_ready;
  logic [9:0] carX = '0, carY = '0;
  logic [1:0] carOrient = '0;
  logic [3:0] carIndex = '0;
  logic       result_valid, collision, out_of_bounds;
  logic [3:0] hit_index;

  collision_scanner #(.NUM_CARS(N)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_orient(wr_orient), .wr_valid(wr_valid),
    .query_valid(query_valid), .query_ready(query_ready),
    .carX(carX), .carY(carY), .carOrient(carOrient), .carIndex(carIndex),
    .result_valid(result_valid), .collision(collision),
    .hit_index(hit_index), .out_of_bounds(out_of_bounds)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference board model
  int m_x[N], m_y[N], m_o[N];
  bit m_v[N];

  typedef struct {
    bit col;
    int hit;
    bit oob;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];

  function automatic void dims(input int o, output int w, output int h);
    case (o)
      0: begin w = 80;  h = 40;  end
      1: begin w = 40;  h = 80;  end
      2: begin w = 120; h = 40;  end
      default: begin w = 40; h = 120; end
    endcase
  endfunction

  function automatic exp_t model(input int qx, input int qy, input int qo, input int qi);
    exp_t e;
    int qw, qh, ew, eh, hit;
    dims(qo, qw, qh);
    hit = -1;
    for (int i = 0; i < N; i++) begin
      dims(m_o[i], ew, eh);
      if (hit < 0 && i != qi && m_v[i] &&
          qx < m_x[i] + ew && m_x[i] < qx + qw &&
          qy < m_y[i] + eh && m_y[i] < qy + qh)
        hit = i;
    end
    e.oob = (qx + qw > 640) || (qy + qh > 480);
    e.col = e.oob || (hit >= 0);
    e.hit = (hit < 0) ? 0 : hit;
`ifdef COLLISION_EARLY_EXIT_EN
    e.lat = (hit >= 0) ? hit + 2 : N + 1;
`else
    e.lat = N + 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Monitor
  bit prev_rv = 1'b0;
  always @(negedge clk) begin
    if (result_valid) begin
      exp_t e;
      if (prev_rv) check("rv_pulse_width", 1, 0);
      if (sb.size() == 0) begin
        check("rv_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("collision", int'(collision), int'(e.col));
        check("hit_index", int'(hit_index), e.hit);
        check("out_of_bounds", int'(out_of_bounds), int'(e.oob));
        check("latency", cycle - e.acc, e.lat);
      end
    end
    prev_rv = result_valid;
  end

  task automatic wait_ready();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (query_ready) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL ready_timeout: query_ready stayed 0 for 100 cycles");
  endtask

  task automatic drive_write(input int idx, input int x, input int y, input int o, input bit v);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_x = 10'(x); wr_y = 10'(y);
    wr_orient = 2'(o); wr_valid = v;
  endtask

  task automatic write_entry(input int idx, input int x, input int y, input int o, input bit v);
    wait_ready();
    drive_write(idx, x, y, o, v);
    m_x[idx] = x; m_y[idx] = y; m_o[idx] = o; m_v[idx] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Optional same-cycle write (commits, seen by scan) and optional write
  // during the scan (dropped, model untouched).
  task automatic do_query(input int x, input int y, input int o, input int idx,
                          input bit same_wr, input bit scan_wr);
    exp_t e;
    int wi, wx, wy, wo;
    bit wv;
    wait_ready();
    wi = $urandom_range(0, N - 1); wx = $urandom_range(0, 600);
    wy = $urandom_range(0, 440);   wo = $urandom_range(0, 3);
    wv = 1'b1;
    if (same_wr) begin
      drive_write(wi, wx, wy, wo, wv);
      m_x[wi] = wx; m_y[wi] = wy; m_o[wi] = wo; m_v[wi] = wv;
    end
    query_valid = 1'b1; carX = 10'(x); carY = 10'(y);
    carOrient = 2'(o); carIndex = 4'(idx);
    e = model(x, y, o, idx);
    @(posedge clk);
    e.acc = cycle;
    sb.push_back(e);
    @(negedge clk);
    query_valid = 1'b0;
    wr_en = 1'b0;
    if (scan_wr) begin
      drive_write($urandom_range(0, N - 1), $urandom_range(0, 600),
                  $urandom_range(0, 440), $urandom_range(0, 3), 1'b1);
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_o[i] = 0; m_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_query_ready", int'(query_ready), 1);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_collision", int'(collision), 0);
    check("rst_hit_index", int'(hit_index), 0);
    check("rst_oob", int'(out_of_bounds), 0);

    // Basic hit, miss, self-skip
    write_entry(0, 10, 10, 1, 1'b1);
    do_query(10, 20, 0, 1, 1'b0, 1'b0);
    do_query(10, 130, 0, 1, 1'b0, 1'b0);
    do_query(10, 10, 1, 0, 1'b0, 1'b0);

    // Bounds: 600+80 exceeds, 560+80 exactly fits
    write_entry(0, 10, 10, 1, 1'b0);
    do_query(600, 10, 0, 2, 1'b0, 1'b0);
    do_query(560, 10, 0, 2, 1'b0, 1'b0);
    do_query(10, 440, 1, 2, 1'b0, 1'b0);
    do_query(10, 400, 1, 2, 1'b0, 1'b0);

    // Two hits -> lowest wins; touching edge only -> no hit
    write_entry(3, 100, 100, 0, 1'b1);
    write_entry(7, 110, 110, 0, 1'b1);
    write_entry(9, 200, 105, 0, 1'b1);
    do_query(120, 105, 0, 0, 1'b0, 1'b0);
    write_entry(3, 100, 100, 0, 1'b0);
    write_entry(7, 110, 110, 0, 1'b0);
    do_query(120, 105, 0, 0, 1'b0, 1'b0);
    write_entry(15, 150, 300, 3, 1'b1);
    do_query(150, 400, 0, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        write_entry($urandom_range(0, N - 1), $urandom_range(0, 600),
                    $urandom_range(0, 440), $urandom_range(0, 3),
                    $urandom_range(0, 3) != 0);
      else
        do_query($urandom_range(0, 620), $urandom_range(0, 470),
                 $urandom_range(0, 3), $urandom_range(0, N - 1),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset during a scan; last completed result has collision=1, hit_index=3
    write_entry(3, 100, 100, 0, 1'b1);
    do_query(120, 105, 0, 0, 1'b0, 1'b0);
    do_query(300, 300, 0, 5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    check("scanrst_result_valid", int'(result_valid), 0);
    check("scanrst_query_ready", int'(query_ready), 1);
    check("scanrst_collision", int'(collision), 0);
    check("scanrst_hit_index", int'(hit_index), 0);
    check("scanrst_oob", int'(out_of_bounds), 0);
    do_query(120, 105, 0, 0, 1'b0, 1'b0);

    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
